// File: rtl/q_pulse_meas.sv
`default_nettype none
// ============================================================================
// q_pulse_meas : counts rising edges of an async pulse train, ends each train
//                on a watchdog gap and reports count * Q_PER_PULSE (saturated).
// Revision     : 1.0
// ============================================================================
module q_pulse_meas #(
  parameter int BUS_WIDTH     = 10,
  parameter int WTD_BUS_WIDTH = 3,
  parameter int Q_PER_PULSE   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 q_serialized,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 overflow
);

  localparam int PROD_W = BUS_WIDTH + $clog2(Q_PER_PULSE + 1);
  // One counter serves both the end-of-train gap and the longer arm timeout.
  localparam int WD_W   = WTD_BUS_WIDTH + 2;
  localparam logic [WD_W-1:0]      GAP_LAST = WD_W'((2 ** WTD_BUS_WIDTH) - 2);
  localparam logic [WD_W-1:0]      ARM_LAST = WD_W'((4 * (2 ** WTD_BUS_WIDTH)) - 1);
  localparam logic [BUS_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [PROD_W-1:0]    PROD_MAX = PROD_W'(CNT_MAX);
  localparam logic [PROD_W-1:0]    Q_SCALE  = PROD_W'(Q_PER_PULSE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 sync_meta_q, sync_meta_d;
  logic                 sync_q, sync_d;
  logic                 sync_dly_q, sync_dly_d;
  logic                 edge_q, edge_d;
  logic [BUS_WIDTH-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [BUS_WIDTH-1:0] q_measured_q, q_measured_d;
  logic                 ready_q, ready_d;
  logic                 overflow_q, overflow_d;
  logic [PROD_W-1:0]    prod;
  logic                 run;

  always_comb begin
    sync_meta_d = q_serialized;
    sync_d      = sync_meta_q;
    sync_dly_d  = sync_q;
    edge_d      = sync_q & ~sync_dly_q;
  end

  assign prod = PROD_W'(cnt_q) * Q_SCALE;
  assign run  = enable & start;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    q_measured_d = q_measured_q;
    overflow_d   = overflow_q;
    ready_d      = 1'b0;

    if (!run) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
          cnt_d   = '0;
          wd_d    = '0;
        end
        S_ARMED: begin
          if (edge_q) begin
            state_d = S_COUNT;
            cnt_d   = BUS_WIDTH'(1);
            wd_d    = '0;
          end else if (wd_q == ARM_LAST) begin
            state_d = S_DONE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_COUNT: begin
          // An edge coinciding with gap expiry keeps the train alive.
          if (edge_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + BUS_WIDTH'(1);
            wd_d  = '0;
          end else if (wd_q == GAP_LAST) begin
            state_d = S_DONE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_DONE: begin
          // A train starting right in the report cycle is not lost.
          if (edge_q) begin
            state_d = S_COUNT;
            cnt_d   = BUS_WIDTH'(1);
          end else begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end
          wd_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          wd_d    = '0;
        end
      endcase
    end

    if (state_d == S_DONE) begin
      ready_d      = 1'b1;
      overflow_d   = (prod > PROD_MAX);
      q_measured_d = (prod > PROD_MAX) ? CNT_MAX : prod[BUS_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_meta_q  <= 1'b0;
      sync_q       <= 1'b0;
      sync_dly_q   <= 1'b0;
      edge_q       <= 1'b0;
      cnt_q        <= '0;
      wd_q         <= '0;
      q_measured_q <= '0;
      ready_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_meta_q  <= sync_meta_d;
      sync_q       <= sync_d;
      sync_dly_q   <= sync_dly_d;
      edge_q       <= edge_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      q_measured_q <= q_measured_d;
      ready_q      <= ready_d;
      overflow_q   <= overflow_d;
    end
  end

  assign q_measured = q_measured_q;
  assign ready      = ready_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_q_pulse_meas.sv
`default_nettype none
// Bench for q_pulse_meas: directed + random pulse trains scored against a
// train-level model built from edge times.
module tb_q_pulse_meas;
  localparam int BW      = 10;
  localparam int WBW     = 3;
  localparam int QPP     = 3;
  localparam int WTD_GAP = 2 ** WBW - 1;
  localparam int ARM_TO  = 4 * 2 ** WBW;
  localparam int QMAX    = 2 ** BW - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          q_serialized = 1'b0;
  logic [BW-1:0] q_measured;
  logic          ready;
  logic          overflow;

  q_pulse_meas #(.BUS_WIDTH(BW), .WTD_BUS_WIDTH(WBW), .Q_PER_PULSE(QPP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .q_serialized(q_serialized), .q_measured(q_measured),
    .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Edge times: the cycle on which each rising edge is counted.
  int E[$];
  int obs_c[$];
  int obs_q[$];
  int obs_o[$];
  int exp_c[$];
  int exp_q[$];
  int exp_o[$];
  logic prev_ready = 1'b0;
  int   back_to_back = 0;

  always @(negedge clk) begin
    if (rst_n && ready) begin
      obs_c.push_back(cyc);
      obs_q.push_back(int'(q_measured));
      obs_o.push_back(int'(overflow));
    end
    if (prev_ready && ready) back_to_back <= back_to_back + 1;
    prev_ready <= ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    q_serialized = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    q_serialized = 1'b1;
    E.push_back(cyc + 4);
    repeat (hi) @(negedge clk);
    q_serialized = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Trains: edges no more than WTD_GAP cycles apart belong together; a train
  // reports WTD_GAP cycles after its last edge. An empty arm window reports 0.
  task automatic build_expected(input int a, input int p);
    int s, w, i, n, last, d, prod;
    exp_c.delete(); exp_q.delete(); exp_o.delete();
    s = a + 1;
    w = a + ARM_TO;
    i = 0;
    while (i < E.size() && E[i] < s) i++;
    forever begin
      if (i < E.size() && E[i] <= w) begin
        n = 1; last = E[i]; i++;
        while (i < E.size() && E[i] - last <= WTD_GAP) begin
          n++; last = E[i]; i++;
        end
        d = last + WTD_GAP;
      end else begin
        n = 0;
        d = w;
      end
      if (d >= p) break;
      prod = n * QPP;
      exp_c.push_back(d);
      exp_q.push_back(prod > QMAX ? QMAX : prod);
      exp_o.push_back(prod > QMAX ? 1 : 0);
      w = d + 1 + ARM_TO;
    end
  endtask

  task automatic arm(output int a);
    enable = 1'b0; start = 1'b0;
    idle(5);
    E.delete(); obs_c.delete(); obs_q.delete(); obs_o.delete();
    enable = 1'b1; start = 1'b1;
    a = cyc + 1;
  endtask

  task automatic end_seg(input string tag, input int a, input bit via_start);
    int p;
    if (via_start) start = 1'b0; else enable = 1'b0;
    p = cyc + 1;
    build_expected(a, p);
    idle(2);
    chk($sformatf("%s count", tag), obs_c.size(), exp_c.size());
    foreach (exp_c[k]) begin
      if (k < obs_c.size()) begin
        chk($sformatf("%s[%0d] cycle", tag, k), obs_c[k], exp_c[k]);
        chk($sformatf("%s[%0d] q", tag, k), obs_q[k], exp_q[k]);
        chk($sformatf("%s[%0d] ovf", tag, k), obs_o[k], exp_o[k]);
      end
    end
  endtask

  initial begin
    int a;
    int ntr, np;
    repeat (3) @(negedge clk);
    chk("reset q", q_measured, 0);
    chk("reset ready", ready, 0);
    chk("reset ovf", overflow, 0);
    rst_n = 1'b1;

    arm(a);
    repeat (5) pulse(2, 2);
    idle(25);
    end_seg("t1", a, 1'b0);
    if (obs_c.size() > 0) begin
      chk("t1 q", obs_q[0], 15);
      chk("t1 latency", obs_c[0] - (E[E.size()-1] - 3), 10);
    end

    arm(a);
    repeat (400) pulse(2, 2);
    idle(12);
    repeat (2) pulse(2, 2);
    idle(20);
    end_seg("t2", a, 1'b1);
    if (obs_c.size() >= 2) begin
      chk("t2 sat q", obs_q[0], QMAX);
      chk("t2 sat ovf", obs_o[0], 1);
      chk("t2 next q", obs_q[1], 6);
      chk("t2 next ovf", obs_o[1], 0);
    end

    arm(a);
    idle(80);
    end_seg("t3", a, 1'b0);
    if (obs_c.size() >= 2) begin
      chk("t3 first timeout", obs_c[0] - a, 32);
      chk("t3 repeat period", obs_c[1] - obs_c[0], 33);
      chk("t3 q", obs_q[0], 0);
    end

    arm(a);
    repeat (2) pulse(2, 2);
    pulse(2, 5);
    repeat (3) pulse(2, 2);
    idle(20);
    end_seg("t4 gap6", a, 1'b0);
    if (obs_c.size() >= 1) chk("t4 gap6 q", obs_q[0], 18);

    arm(a);
    repeat (2) pulse(2, 2);
    pulse(2, 6);
    repeat (3) pulse(2, 2);
    idle(20);
    end_seg("t4 gap7", a, 1'b1);
    if (obs_c.size() >= 2) begin
      chk("t4 gap7 q0", obs_q[0], 9);
      chk("t4 gap7 q1", obs_q[1], 9);
    end

    arm(a);
    repeat (3) pulse(2, 2);
    end_seg("t5 abort", a, 1'b0);
    repeat (2) pulse(2, 2);
    idle(15);
    chk("t5 no ready", obs_c.size(), 0);
    chk("t5 q held", q_measured, 9);
    chk("t5 ovf held", overflow, 0);
    arm(a);
    repeat (2) pulse(2, 2);
    idle(20);
    end_seg("t5 resume", a, 1'b0);
    if (obs_c.size() >= 1) chk("t5 resume q", obs_q[0], 6);

    arm(a);
    repeat (2) pulse(2, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async q", q_measured, 0);
    chk("t6 async ready", ready, 0);
    chk("t6 async ovf", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    arm(a);
    repeat (4) pulse(2, 2);
    idle(20);
    end_seg("t6 rearm", a, 1'b0);
    if (obs_c.size() >= 1) chk("t6 q", obs_q[0], 12);

    for (int s = 0; s < 6; s++) begin
      arm(a);
      ntr = $urandom_range(1, 3);
      for (int t = 0; t < ntr; t++) begin
        np = $urandom_range(1, 8);
        for (int j = 0; j < np; j++) pulse($urandom_range(1, 3), $urandom_range(1, 6));
        idle($urandom_range(0, 45));
      end
      idle($urandom_range(0, 40));
      end_seg($sformatf("rand%0d", s), a, 1'($urandom_range(0, 1)));
    end

    chk("ready back-to-back", back_to_back, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
